// File: rtl/toggle_bank_pkg.sv
// Shared constants for the front-panel toggle bank: channel indices and holdoff default.
// Optional build macro TOGGLE_BANK_HOLDOFF_EN enables per-channel holdoff counters.
package toggle_bank_pkg;

  localparam int CH_MODE         = 0;
  localparam int CH_ALARM        = 1;
  localparam int CH_H24          = 2;
  localparam int CH_CHIME        = 3;
  localparam int MAX_CH          = 16;
  localparam int HOLDOFF_DEFAULT = 3;

  // Counter width for a holdoff window; never collapses to zero bits.
  function automatic int hold_w(input int holdoff);
    return (holdoff < 1) ? 1 : $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/toggle_bank_if.sv
// Bus between button conditioning, the toggle bank and the clock control FSMs.
// Optional build macro TOGGLE_BANK_HOLDOFF_EN does not change this interface.
interface toggle_bank_if #(
  parameter int N = 4
);
  // No valid/ready: every bit of signal/set/clr is a request for the cycle it is high,
  // always accepted; signal_tog/changed are registered and valid every cycle after reset.
  logic [N-1:0] signal;
  logic [N-1:0] set;
  logic [N-1:0] clr;
  logic [N-1:0] signal_tog;
  logic [N-1:0] changed;

  modport master (output signal, set, clr, input signal_tog, changed);
  modport slave  (input signal, set, clr, output signal_tog, changed);
endinterface

// File: rtl/toggle_bank_cell.sv
// One toggle channel: edge detect, optional holdoff, clr > set > event priority.
// Holdoff counter present only when TOGGLE_BANK_HOLDOFF_EN is defined.
module toggle_bank_cell
  import toggle_bank_pkg::*;
#(
  parameter int EDGE    = 1,
  parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
  input  logic ck,
  input  logic reset,
  input  logic signal_i,
  input  logic set_i,
  input  logic clr_i,
  input  logic tog_i,
  input  logic load_i,
  output logic cand_o,
  output logic rise_o,
  output logic ev_acc_o
);

  logic sig_prev_q, sig_prev_d;
  logic ev;
  logic busy;

`ifdef TOGGLE_BANK_HOLDOFF_EN
  localparam int CW = hold_w(HOLDOFF);
  logic [CW-1:0] cnt_q, cnt_d;

  assign busy = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = CW'(HOLDOFF);
    else if (busy) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign busy       = 1'b0;
  assign unused_cfg = (HOLDOFF > 0) ? load_i : 1'b0;
`endif

  always_comb begin
    sig_prev_d = signal_i;
    ev         = (EDGE != 0) ? (signal_i & ~sig_prev_q) : signal_i;
    ev_acc_o   = ev & ~busy & ~clr_i & ~set_i;
    if (clr_i)             cand_o = 1'b0;
    else if (set_i)        cand_o = 1'b1;
    else if (ev & ~busy)   cand_o = ~tog_i;
    else                   cand_o = tog_i;
    rise_o = cand_o & ~tog_i;
  end

  // All-ones after reset so a button held through reset is not seen as a fresh press.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) sig_prev_q <= 1'b1;
    else       sig_prev_q <= sig_prev_d;
  end

endmodule

// File: rtl/toggle_bank.sv
// N-channel toggle register with optional radio-button grouping and a change strobe.
// Build macro TOGGLE_BANK_HOLDOFF_EN adds a per-channel ignore window after each toggle.
module toggle_bank
  import toggle_bank_pkg::*;
#(
  parameter int           N         = 4,
  parameter logic [N-1:0] RESET_VAL = {N{1'b0}},
  parameter int           EDGE      = 1,
  parameter int           ONEHOT    = 0,
  parameter int           HOLDOFF   = HOLDOFF_DEFAULT
) (
  input logic         ck,
  input logic         reset,
  toggle_bank_if.slave bus
);

  logic [N-1:0] cand, rise, ev_acc, win, load;
  logic [N-1:0] tog_q, tog_d, chg_q, chg_d;

  for (genvar i = 0; i < N; i++) begin : g_cell
    toggle_bank_cell #(
      .EDGE    (EDGE),
      .HOLDOFF (HOLDOFF)
    ) u_cell (
      .ck       (ck),
      .reset    (reset),
      .signal_i (bus.signal[i]),
      .set_i    (bus.set[i]),
      .clr_i    (bus.clr[i]),
      .tog_i    (tog_q[i]),
      .load_i   (load[i]),
      .cand_o   (cand[i]),
      .rise_o   (rise[i]),
      .ev_acc_o (ev_acc[i])
    );
  end

  // Lowest rising channel wins the radio group; only its own event arms its holdoff.
  always_comb begin
    win = rise & (~rise + N'(1));
    if ((ONEHOT != 0) && (rise != '0)) begin
      tog_d = win;
      load  = ev_acc & win;
    end else begin
      tog_d = cand;
      load  = ev_acc;
    end
    chg_d = tog_d ^ tog_q;
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      tog_q <= RESET_VAL;
      chg_q <= '0;
    end else begin
      tog_q <= tog_d;
      chg_q <= chg_d;
    end
  end

  assign bus.signal_tog = tog_q;
  assign bus.changed    = chg_q;

endmodule

// File: tb/tb_toggle_bank.sv
// Bench for toggle_bank: three configurations driven by directed and random requests,
// checked every cycle against a behavioural model; honours TOGGLE_BANK_HOLDOFF_EN.
module tb_toggle_bank;
  localparam int N  = 4;
  localparam int HO = 3;

  // ---------------- clock / reset ----------------
  logic ck = 1'b0;
  logic reset;
  always #5 ck = ~ck;

  toggle_bank_if #(.N(N)) if_a ();
  toggle_bank_if #(.N(N)) if_b ();
  toggle_bank_if #(.N(N)) if_c ();

  logic [N-1:0] sig_v[3];
  logic [N-1:0] set_v[3];
  logic [N-1:0] clr_v[3];

  assign if_a.signal = sig_v[0];
  assign if_a.set    = set_v[0];
  assign if_a.clr    = clr_v[0];
  assign if_b.signal = sig_v[1];
  assign if_b.set    = set_v[1];
  assign if_b.clr    = clr_v[1];
  assign if_c.signal = sig_v[2];
  assign if_c.set    = set_v[2];
  assign if_c.clr    = clr_v[2];

  // A: edge mode, non-zero reset value; B: level mode; C: edge mode radio group.
  toggle_bank #(.N(N), .RESET_VAL(4'b0101), .EDGE(1), .ONEHOT(0), .HOLDOFF(HO))
    u_a (.ck(ck), .reset(reset), .bus(if_a));
  toggle_bank #(.N(N), .RESET_VAL(4'b0000), .EDGE(0), .ONEHOT(0), .HOLDOFF(HO))
    u_b (.ck(ck), .reset(reset), .bus(if_b));
  toggle_bank #(.N(N), .RESET_VAL(4'b0000), .EDGE(1), .ONEHOT(1), .HOLDOFF(HO))
    u_c (.ck(ck), .reset(reset), .bus(if_c));

  function automatic logic [N-1:0] p_rv(input int k);
    return (k == 0) ? 4'b0101 : 4'b0000;
  endfunction
  function automatic bit p_edge(input int k);
    return k != 1;
  endfunction
  function automatic bit p_onehot(input int k);
    return k == 2;
  endfunction

  function automatic logic [N-1:0] dut_tog(input int k);
    case (k)
      0:       return if_a.signal_tog;
      1:       return if_b.signal_tog;
      default: return if_c.signal_tog;
    endcase
  endfunction
  function automatic logic [N-1:0] dut_chg(input int k);
    case (k)
      0:       return if_a.changed;
      1:       return if_b.changed;
      default: return if_c.changed;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_tog[3];
  logic [N-1:0] m_chg[3];
  logic [N-1:0] m_prev[3];
  int           ready_at[3][N];
  int           cyc = 0;

  task automatic model_step(input int k);
    logic [N-1:0] nxt;
    bit           acts[N];
    bit           ev;
    int           w;
    w = -1;
    for (int i = 0; i < N; i++) begin
      ev = p_edge(k) ? (sig_v[k][i] && !m_prev[k][i]) : sig_v[k][i];
`ifdef TOGGLE_BANK_HOLDOFF_EN
      if (cyc < ready_at[k][i]) ev = 1'b0;
`endif
      acts[i] = 1'b0;
      if (clr_v[k][i])      nxt[i] = 1'b0;
      else if (set_v[k][i]) nxt[i] = 1'b1;
      else if (ev) begin
        nxt[i]  = !m_tog[k][i];
        acts[i] = 1'b1;
      end else              nxt[i] = m_tog[k][i];
    end
    if (p_onehot(k)) begin
      for (int i = 0; i < N; i++)
        if (nxt[i] && !m_tog[k][i] && w < 0) w = i;
      if (w >= 0) begin
        nxt    = '0;
        nxt[w] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++)
      if (acts[i] && (w < 0 || w == i)) ready_at[k][i] = cyc + HO + 1;
    m_chg[k]  = nxt ^ m_tog[k];
    m_tog[k]  = nxt;
    m_prev[k] = sig_v[k];
  endtask

  always @(posedge ck or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_tog[k]  = p_rv(k);
        m_chg[k]  = '0;
        m_prev[k] = '1;
        for (int i = 0; i < N; i++) ready_at[k][i] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) model_step(k);
      cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input int k, input logic [N-1:0] tog, input logic [N-1:0] chg);
    check({name, "_tog"}, dut_tog(k), tog);
    check({name, "_chg"}, dut_chg(k), chg);
    check({name, "_model_tog"}, m_tog[k], tog);
    check({name, "_model_chg"}, m_chg[k], chg);
  endtask

  always @(negedge ck) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("cyc_tog%0d", k), dut_tog(k), m_tog[k]);
      check($sformatf("cyc_chg%0d", k), dut_chg(k), m_chg[k]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      sig_v[k] = '0;
      set_v[k] = '0;
      clr_v[k] = '0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic clear_all();
    idle();
    for (int k = 0; k < 3; k++) clr_v[k] = '1;
    tick(1);
    idle();
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle();
    for (int k = 0; k < 3; k++) sig_v[k] = '1;
    tick(3);
    reset = 1'b0;
    sig_v[0] = '1;
    tick(2);
    lit("reset_hold", 0, 4'b0101, 4'b0000);

    clear_all();
    lit("cleared_a", 0, 4'b0000, 4'b0000);

    // Edge mode: a held level toggles exactly once.
    sig_v[0] = 4'b0100;
    tick(1);
    lit("edge_first", 0, 4'b0100, 4'b0100);
    tick(1);
    lit("edge_second", 0, 4'b0100, 4'b0000);
    tick(3);
    lit("edge_held", 0, 4'b0100, 4'b0000);
    clear_all();

`ifdef TOGGLE_BANK_HOLDOFF_EN
    sig_v[1] = 4'b0010;
    tick(1); lit("ho_c1", 1, 4'b0010, 4'b0010);
    tick(1); lit("ho_c2", 1, 4'b0010, 4'b0000);
    tick(1); lit("ho_c3", 1, 4'b0010, 4'b0000);
    tick(1); lit("ho_c4", 1, 4'b0010, 4'b0000);
    tick(1); lit("ho_c5", 1, 4'b0000, 4'b0010);
    tick(1); lit("ho_c6", 1, 4'b0000, 4'b0000);
    idle();
    tick(4);
    sig_v[1] = 4'b0010;
    tick(1); lit("ho_rearm", 1, 4'b0010, 4'b0010);
    sig_v[1] = 4'b0000;
    clr_v[1] = 4'b0010;
    tick(1); lit("ho_clr", 1, 4'b0000, 4'b0010);
`else
    sig_v[1] = 4'b0001;
    tick(1); lit("level_c1", 1, 4'b0001, 4'b0001);
    tick(1); lit("level_c2", 1, 4'b0000, 4'b0001);
    tick(1); lit("level_c3", 1, 4'b0001, 4'b0001);
    sig_v[1] = 4'b0000;
    tick(1); lit("level_stop", 1, 4'b0001, 4'b0000);
`endif
    clear_all();

    // clr beats set; requests matching the current state do nothing.
    set_v[0] = 4'b0011;
    clr_v[0] = 4'b0110;
    tick(1); lit("set_clr", 0, 4'b0001, 4'b0001);
    set_v[0] = 4'b0001;
    clr_v[0] = 4'b1000;
    tick(1); lit("noop_req", 0, 4'b0001, 4'b0000);
    idle();
    clear_all();

    // Radio group: two simultaneous rises, lowest index wins.
    set_v[2] = 4'b0100;
    tick(1); lit("oh_set", 2, 4'b0100, 4'b0100);
    set_v[2] = 4'b0000;
    sig_v[2] = 4'b1010;
    tick(1); lit("oh_arb", 2, 4'b0010, 4'b0110);
    idle();
    tick(2);

    // Random traffic with an asynchronous reset pulse part-way through.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        sig_v[k] = N'($urandom_range(0, 15));
        set_v[k] = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
        clr_v[k] = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      end
      if (n == 200) begin
        #2 reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end else begin
        tick(1);
      end
    end

    idle();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
